sequence_dispatcher: RTL and testbench
======================================

// Module: sequence_dispatcher
// PURPOSE
//  Scheduler between sequence_separator and the downstream decoder/display.
//  On each separator send event it queues FirstSeq, then SecSeq, into a FIFO.
//  Empty (10'h3FF) words are dropped. Queued words are issued one at a time
//  on a valid/ready handshake, so that the decoder never sees two words in one cycle.
// PARAMETERS
//  SEQ_W  10  encoded sequence width: 5 symbols x 2b, MSB pair first
//  DEPTH  8   FIFO entries; power of 2, >=2
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  sent_flag_in  in   1      separator sentFlag (level; event = rising edge)
//  first_seq     in   SEQ_W  separator FirstSeq
//  sec_seq       in   SEQ_W  separator SecSeq
//  seq_out       out  SEQ_W  head-of-queue word; 10'h3FF when !seq_valid
//  seq_valid     out  1      queue non-empty
//  seq_ready     in   1      consumer accepts seq_out this cycle
//  fifo_count    out  $clog2(DEPTH)+1  words queued, 0..DEPTH
//  busy          out  1      capture FSM not IDLE
//  overflow      out  1      sticky: a non-empty word was dropped on full
//  ovf_clr       in   1      synchronous clear of overflow
// BEHAVIOUR
//  Reset (async): FIFO emptied, ptrs/count 0, mem all 1s, FSM IDLE, hold regs 3FF,
//   overflow 0, sf_q=1. Outputs: seq_out=3FF, seq_valid=0, fifo_count=0, busy=0.
//   sf_q=1 means a flag held high across reset release is NOT an event.
//  Event: edge k samples sent_flag_in=1 with sf_q=0. sf_q <= sent_flag_in every cycle.
//  FSM (2 states):
//   IDLE: on event: hold_sec<=sec_seq; push first_seq if !=3FF; ->PUSH_SEC.
//   PUSH_SEC: push hold_sec if !=3FF; ->IDLE. busy=1 only in PUSH_SEC.
//   Events are >=2 cycles apart (rise needs a fall), so no event hits PUSH_SEC.
//   If one does anyway, it is ignored.
//  Latency: first word visible (seq_valid=1) after edge k; second after k+1.
//  Space word 10'h2FF ([9:8]=10) is a valid word and is always queued.
//  Handshake: pop when seq_valid&&seq_ready. seq_out/seq_valid depend
//   combinationally on FIFO state only, never on seq_ready.
//   seq_out holds stable until popped.
//  FIFO: wr/rd ptrs $clog2(DEPTH) bits, wrap modulo DEPTH; count +push -pop.
//   Full: push with no pop -> word dropped, overflow<=1, count stays DEPTH.
//   Full: push with pop same cycle -> both occur, count stays DEPTH.
//   Empty: pop is impossible (valid=0). A push leaves count 1.
//   A push onto an empty FIFO appears on seq_out the next cycle (no bypass).
//  overflow: set wins over ovf_clr in the same cycle.
//  Reset mid-operation: all queued and held words are lost. No partial pushes.
// STRUCTURE
//  morse_pkg: SEQ_W=10, SEQ_EMPTY=10'h3FF, SEQ_SPACE=10'h2FF,
//   symbol codes DOT/DASH/SPACE/NONE, FSM state enum.
//  Sub-module seq_fifo (DEPTH, SEQ_W): sync FIFO, async reset, push/pop/full/
//   empty/count/overflow-drop. The top level holds the edge detect and FSM only.
// TESTING
//  1 Reset with sent_flag_in=1, then release -> no push; count=0, seq_out=3FF.
//  2 Event first=0x0BF, sec=0x2FF, ready=0 -> count 1 after k, 2 after k+1.
//    Then pop in the order 0BF, 2FF.
//  3 Event first=0x2FF, sec=0x3FF -> exactly one word (2FF) is queued, busy=1 for 1 cycle.
//  4 DEPTH=8, ready=0, 5 events of two non-empty words each -> count=8, overflow=1.
//    The last 2 words are dropped. ovf_clr clears overflow.
//  5 Full, ready=1 during a push -> count stays 8, order preserved; wrap-around check.
//    Drain all 8 and check FIFO order, then count=0, seq_valid=0.
//  6 rst asserted during PUSH_SEC -> outputs at reset values immediately.
//    After release the held sec word is never emitted.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared encodings for the Morse sequence path: 5 symbols x 2 bits, MSB pair first.
package morse_pkg;

    localparam int         SEQ_W     = 10;
    localparam logic [9:0] SEQ_EMPTY = 10'h3FF;
    localparam logic [9:0] SEQ_SPACE = 10'h2FF;

    localparam logic [1:0] SYM_DOT   = 2'b00;
    localparam logic [1:0] SYM_DASH  = 2'b01;
    localparam logic [1:0] SYM_SPACE = 2'b10;
    localparam logic [1:0] SYM_NONE  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_PUSH_SEC = 1'b1
    } disp_state_t;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous word FIFO with sticky overflow; a push into a full FIFO is dropped
// unless a pop frees a slot in the same cycle.
module seq_fifo #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [SEQ_W-1:0]         push_data,
    input  logic                     pop,
    output logic [SEQ_W-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int                 PTR_W      = $clog2(DEPTH);
    localparam int                 CNT_W      = PTR_W + 1;
    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [SEQ_W-1:0]   EMPTY_WORD = {SEQ_W{1'b1}};

    logic [SEQ_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             full_s;
    logic             empty_s;
    logic             do_pop_s;
    logic             do_push_s;
    logic             drop_s;

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign do_pop_s  = pop && !empty_s;
    assign do_push_s = push && (!full_s || do_pop_s);
    assign drop_s    = push && full_s && !do_pop_s;

    // Storage array and pointers; memory resets to the empty word pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= EMPTY_WORD;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a new drop takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end
    end

    assign pop_data = empty_s ? EMPTY_WORD : mem_r[rd_ptr_r];
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/sequence_dispatcher.sv
// Turns each separator send event into up to two FIFO pushes (FirstSeq, then SecSeq),
// dropping empty words, and presents the queue head on a valid/ready interface.
module sequence_dispatcher #(
    parameter int SEQ_W = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sent_flag_in,
    input  logic [SEQ_W-1:0]         first_seq,
    input  logic [SEQ_W-1:0]         sec_seq,
    output logic [SEQ_W-1:0]         seq_out,
    output logic                     seq_valid,
    input  logic                     seq_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    import morse_pkg::*;

    localparam logic [SEQ_W-1:0] EMPTY_WORD = {SEQ_W{1'b1}};

    disp_state_t      state_r;
    disp_state_t      next_state_s;
    logic             sf_q_r;
    logic [SEQ_W-1:0] hold_sec_r;
    logic             event_s;
    logic             push_s;
    logic [SEQ_W-1:0] push_data_s;
    logic             busy_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;

    // sf_q resets high so a flag already high at reset release is not an event.
    assign event_s = sent_flag_in && !sf_q_r;

    // Flag history, FSM state and the held second word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sf_q_r     <= 1'b1;
            state_r    <= ST_IDLE;
            hold_sec_r <= EMPTY_WORD;
        end else begin
            sf_q_r  <= sent_flag_in;
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && event_s) begin
                hold_sec_r <= sec_seq;
            end
        end
    end

    // Next-state logic; an event arriving in PUSH_SEC is ignored.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (event_s) begin
                    next_state_s = ST_PUSH_SEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PUSH_SEC: next_state_s = ST_IDLE;
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // Push request and busy indication for the current state.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = EMPTY_WORD;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (event_s && (first_seq != EMPTY_WORD)) begin
                    push_s      = 1'b1;
                    push_data_s = first_seq;
                end else begin
                    push_s      = 1'b0;
                    push_data_s = EMPTY_WORD;
                end
            end
            ST_PUSH_SEC: begin
                busy_s      = 1'b1;
                push_s      = (hold_sec_r != EMPTY_WORD);
                push_data_s = hold_sec_r;
            end
            default: begin
                push_s      = 1'b0;
                push_data_s = EMPTY_WORD;
                busy_s      = 1'b0;
            end
        endcase
    end

    seq_fifo #(
        .DEPTH (DEPTH),
        .SEQ_W (SEQ_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (seq_ready),
        .pop_data  (seq_out),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    assign seq_valid = !fifo_empty_s;
    assign busy      = busy_s;

endmodule

// File: tb/tb_sequence_dispatcher.sv
// Directed bench for sequence_dispatcher: reset, event latency, empty-word drop,
// overflow, full push+pop with wrap-around, and reset during PUSH_SEC.
module tb_sequence_dispatcher;

    logic       clk;
    logic       rst;
    logic       sent_flag_in;
    logic [9:0] first_seq;
    logic [9:0] sec_seq;
    logic [9:0] seq_out;
    logic       seq_valid;
    logic       seq_ready;
    logic [3:0] fifo_count;
    logic       busy;
    logic       overflow;
    logic       ovf_clr;

    int n_cmp;
    int n_err;

    logic [9:0] exp_order [8];

    sequence_dispatcher #(
        .SEQ_W (10),
        .DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sent_flag_in (sent_flag_in),
        .first_seq    (first_seq),
        .sec_seq      (sec_seq),
        .seq_out      (seq_out),
        .seq_valid    (seq_valid),
        .seq_ready    (seq_ready),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic event_pair(input logic [9:0] f, input logic [9:0] s);
        first_seq    = f;
        sec_seq      = s;
        sent_flag_in = 1'b1;
        tick();
        tick();
        sent_flag_in = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        sent_flag_in = 1'b1;
        first_seq    = 10'h3FF;
        sec_seq      = 10'h3FF;
        seq_ready    = 1'b0;
        ovf_clr      = 1'b0;

        // 1: reset with flag held high, then release: no event
        tick();
        tick();
        check("rst_out",   32'(seq_out),    32'h3FF);
        check("rst_valid", 32'(seq_valid),  32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_ovf",   32'(overflow),   32'h0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("held_flag_count", 32'(fifo_count), 32'h0);
        check("held_flag_out",   32'(seq_out),    32'h3FF);
        check("held_flag_busy",  32'(busy),       32'h0);
        sent_flag_in = 1'b0;
        tick();

        // 2: two words, latency and order
        first_seq    = 10'h0BF;
        sec_seq      = 10'h2FF;
        sent_flag_in = 1'b1;
        tick();
        check("t2_cnt_k",   32'(fifo_count), 32'h1);
        check("t2_busy_k",  32'(busy),       32'h1);
        check("t2_valid_k", 32'(seq_valid),  32'h1);
        check("t2_head_k",  32'(seq_out),    32'h0BF);
        tick();
        check("t2_cnt_k1",  32'(fifo_count), 32'h2);
        check("t2_busy_k1", 32'(busy),       32'h0);
        sent_flag_in = 1'b0;
        seq_ready    = 1'b1;
        check("t2_pop0", 32'(seq_out), 32'h0BF);
        tick();
        check("t2_pop1", 32'(seq_out),    32'h2FF);
        check("t2_cnt1", 32'(fifo_count), 32'h1);
        tick();
        check("t2_cnt0",   32'(fifo_count), 32'h0);
        check("t2_valid0", 32'(seq_valid),  32'h0);
        check("t2_out0",   32'(seq_out),    32'h3FF);
        seq_ready = 1'b0;

        // 3: space word kept, empty second word dropped
        first_seq    = 10'h2FF;
        sec_seq      = 10'h3FF;
        sent_flag_in = 1'b1;
        tick();
        check("t3_cnt_k",  32'(fifo_count), 32'h1);
        check("t3_busy_k", 32'(busy),       32'h1);
        tick();
        check("t3_cnt_k1",  32'(fifo_count), 32'h1);
        check("t3_busy_k1", 32'(busy),       32'h0);
        check("t3_head",    32'(seq_out),    32'h2FF);
        sent_flag_in = 1'b0;
        seq_ready    = 1'b1;
        tick();
        seq_ready = 1'b0;
        check("t3_drained", 32'(fifo_count), 32'h0);

        // 4: five events into DEPTH=8 with no consumer
        for (int i = 0; i < 4; i++) begin
            event_pair(10'(2 * i), 10'(2 * i + 1));
        end
        check("t4_cnt8",     32'(fifo_count), 32'h8);
        check("t4_ovf_pre",  32'(overflow),   32'h0);
        event_pair(10'h008, 10'h009);
        check("t4_cnt_full", 32'(fifo_count), 32'h8);
        check("t4_ovf_set",  32'(overflow),   32'h1);
        check("t4_head",     32'(seq_out),    32'h000);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'h0);

        // 5: push while full with ready high, then drain across the wrap
        first_seq    = 10'h0AA;
        sec_seq      = 10'h155;
        sent_flag_in = 1'b1;
        seq_ready    = 1'b1;
        tick();
        check("t5_cnt_k",  32'(fifo_count), 32'h8);
        check("t5_head_k", 32'(seq_out),    32'h001);
        tick();
        check("t5_cnt_k1",  32'(fifo_count), 32'h8);
        check("t5_head_k1", 32'(seq_out),    32'h002);
        sent_flag_in = 1'b0;
        seq_ready    = 1'b0;
        check("t5_no_ovf", 32'(overflow), 32'h0);
        exp_order = '{10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h0AA, 10'h155};
        seq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_drain%0d", i), 32'(seq_out), 32'(exp_order[i]));
            tick();
        end
        seq_ready = 1'b0;
        check("t5_cnt0",   32'(fifo_count), 32'h0);
        check("t5_valid0", 32'(seq_valid),  32'h0);

        // 6: reset asserted while in PUSH_SEC
        first_seq    = 10'h011;
        sec_seq      = 10'h022;
        sent_flag_in = 1'b1;
        tick();
        check("t6_busy_k", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_cnt",   32'(fifo_count), 32'h0);
        check("t6_rst_valid", 32'(seq_valid),  32'h0);
        check("t6_rst_out",   32'(seq_out),    32'h3FF);
        check("t6_rst_busy",  32'(busy),       32'h0);
        sent_flag_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t6_after_cnt",   32'(fifo_count), 32'h0);
        check("t6_after_valid", 32'(seq_valid),  32'h0);
        check("t6_after_busy",  32'(busy),       32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
